dot_product_engine: RTL and testbench

Parametrised streaming dot-product engine, successor to `dotProduct`. It accepts `Para_Deg` operand pairs per beat over a valid/ready handshake and multiplies them through a fixed 3-stage pipeline. It accumulates over a run-time vector length, with an optional bias from a previous output and a partial last beat, then presents one saturated or wrapped result on a held valid/ready output. It sits between the operand SRAM read ports and the output SRAM write port, replacing the fixed-length, file-loaded compute path.

---
 rtl/dot_product_pkg.sv | 26 ++
 rtl/dot_product_engine_if.sv | 25 ++
 rtl/dp_lane_tree.sv | 47 ++++
 rtl/dot_product_engine.sv | 122 ++++++++++++
 tb/tb_dot_product_engine.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dot_product_pkg.sv
// Shared state encoding, drain length and width helpers for the dot-product engine.
package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DRAIN_CYCLES = 2;

  function automatic int prod_width(input int dw_in);
    return 2 * dw_in;
  endfunction

  function automatic int lane_sum_width(input int dw_in, input int lanes);
    return 2 * dw_in + $clog2(lanes);
  endfunction

  // One spare bit above the sum of both operands so the overflow compare never wraps.
  function automatic int acc_width(input int dw_out, input int ls_w);
    return dw_out + 1 + ls_w;
  endfunction

endpackage

// File: rtl/dot_product_engine_if.sv
// Operand-beat and result streams of the dot-product engine, both valid/ready.
interface dot_product_engine_if #(
  parameter int Para_Deg       = 4,
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16
);
  logic                              in_valid;
  logic                              in_ready;
  logic [Para_Deg*Data_Width_In-1:0] in_a;
  logic [Para_Deg*Data_Width_In-1:0] in_b;
  logic                              out_valid;
  logic                              out_ready;
  logic [Data_Width_Out-1:0]         out_data;
  logic                              out_sat;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/dp_lane_tree.sv
// Per-lane registered multipliers then a registered lane adder; 2 cycles, no stall.
// Disabled or masked lanes load zero, so bubbles flow through as zero contributions.
module dp_lane_tree
  import dot_product_pkg::*;
#(
  parameter int Para_Deg      = 4,
  parameter int Data_Width_In = 8,
  localparam int PW  = prod_width(Data_Width_In),
  localparam int LSW = lane_sum_width(Data_Width_In, Para_Deg)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              en,
  input  logic [Para_Deg-1:0]               lane_mask,
  input  logic [Para_Deg*Data_Width_In-1:0] a,
  input  logic [Para_Deg*Data_Width_In-1:0] b,
  output logic [LSW-1:0]                    lane_sum
);

  logic [PW-1:0]  prod_q [Para_Deg];
  logic [LSW-1:0] sum_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Para_Deg; i++) prod_q[i] <= '0;
    end else begin
      for (int i = 0; i < Para_Deg; i++) begin
        if (en && lane_mask[i])
          prod_q[i] <= PW'(a[i*Data_Width_In +: Data_Width_In]) *
                       PW'(b[i*Data_Width_In +: Data_Width_In]);
        else
          prod_q[i] <= '0;
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < Para_Deg; i++) sum_d = sum_d + LSW'(prod_q[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lane_sum <= '0;
    else          lane_sum <= sum_d;
  end

endmodule

// File: rtl/dot_product_engine.sv
// Streaming dot product: 3-cycle beat-to-accumulator latency, one beat per cycle in RUN.
// Input stalls only outside RUN; result is held in DONE until out_ready.
module dot_product_engine
  import dot_product_pkg::*;
#(
  parameter int Para_Deg       = 4,
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16,
  parameter int Len_Width      = 8,
  parameter int Saturate       = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [Len_Width-1:0]      vec_beats,
  input  logic                      acc_old,
  input  logic [Data_Width_Out-1:0] bias_in,
  input  logic [Para_Deg-1:0]       last_mask,
  output logic                      busy,
  output logic [Len_Width-1:0]      beat_count,
  dot_product_engine_if.slave       io
);

  localparam int LSW = lane_sum_width(Data_Width_In, Para_Deg);
  localparam int AW  = acc_width(Data_Width_Out, LSW);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  state_t                    state_q, state_d;
  logic [Len_Width-1:0]      vec_beats_q;
  logic [Para_Deg-1:0]       last_mask_q;
  logic [DCW-1:0]            drain_cnt_q;
  logic [Data_Width_Out-1:0] acc_q, acc_upd, init_acc, out_data_q;
  logic                      sat_q, in_ready_q;
  logic                      accept, last_beat, ovf;
  logic [Para_Deg-1:0]       lane_mask;
  logic [LSW-1:0]            lane_sum;
  logic [AW-1:0]             acc_wide;

  assign accept    = io.in_valid & in_ready_q;
  assign last_beat = (beat_count == (vec_beats_q - Len_Width'(1)));
  assign lane_mask = last_beat ? last_mask_q : '1;
  assign init_acc  = acc_old ? bias_in : '0;

  dp_lane_tree #(
    .Para_Deg      (Para_Deg),
    .Data_Width_In (Data_Width_In)
  ) u_lane_tree (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (accept),
    .lane_mask (lane_mask),
    .a         (io.in_a),
    .b         (io.in_b),
    .lane_sum  (lane_sum)
  );

  // A clamped accumulator re-clamps on every later add, so it sticks at max.
  assign acc_wide = AW'(acc_q) + AW'(lane_sum);
  assign ovf      = acc_wide > AW'({Data_Width_Out{1'b1}});

  always_comb begin
    acc_upd = acc_wide[Data_Width_Out-1:0];
    if (ovf && (Saturate != 0)) acc_upd = '1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (vec_beats == '0) ? DONE : RUN;
      RUN:     if (accept && last_beat) state_d = DRAIN;
      DRAIN:   if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == RUN);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_beats_q <= '0;
      last_mask_q <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      drain_cnt_q <= '0;
      beat_count  <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        vec_beats_q <= vec_beats;
        last_mask_q <= last_mask;
        acc_q       <= init_acc;
        sat_q       <= 1'b0;
        out_data_q  <= init_acc;
      end else if (state_q == RUN || state_q == DRAIN) begin
        acc_q <= acc_upd;
        if (ovf) sat_q <= 1'b1;
        if (state_d == DONE) out_data_q <= acc_upd;
      end

      drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + DCW'(1) : '0;

      if (state_q == DONE && io.out_ready) beat_count <= '0;
      else if (accept)                     beat_count <= beat_count + Len_Width'(1);
    end
  end

  assign busy         = (state_q != IDLE);
  assign io.in_ready  = in_ready_q;
  assign io.out_valid = (state_q == DONE);
  assign io.out_data  = out_data_q;
  assign io.out_sat   = sat_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Drives a saturating and a wrapping engine with identical traffic; a monitor scores results.
module tb_dot_product_engine;

  localparam int PD  = 4;
  localparam int DWI = 8;
  localparam int DWO = 16;
  localparam int LW  = 8;

  typedef struct packed {
    logic [DWO-1:0] data;
    logic           sat;
  } exp_t;

  logic clk, reset_n;
  logic start, acc_old;
  logic [LW-1:0]  vec_beats;
  logic [DWO-1:0] bias_in;
  logic [PD-1:0]  last_mask;
  logic in_valid, out_ready;
  logic [PD*DWI-1:0] in_a, in_b;
  logic busy_s, busy_w;
  logic [LW-1:0] bc_s, bc_w;

  int checks = 0;
  int errors = 0;
  exp_t q_s[$];
  exp_t q_w[$];

  dot_product_engine_if #(.Para_Deg(PD), .Data_Width_In(DWI), .Data_Width_Out(DWO)) if_s ();
  dot_product_engine_if #(.Para_Deg(PD), .Data_Width_In(DWI), .Data_Width_Out(DWO)) if_w ();

  assign if_s.in_valid = in_valid;
  assign if_s.in_a = in_a;
  assign if_s.in_b = in_b;
  assign if_s.out_ready = out_ready;
  assign if_w.in_valid = in_valid;
  assign if_w.in_a = in_a;
  assign if_w.in_b = in_b;
  assign if_w.out_ready = out_ready;

  dot_product_engine #(.Para_Deg(PD), .Data_Width_In(DWI), .Data_Width_Out(DWO),
                       .Len_Width(LW), .Saturate(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .vec_beats(vec_beats),
    .acc_old(acc_old), .bias_in(bias_in), .last_mask(last_mask),
    .busy(busy_s), .beat_count(bc_s), .io(if_s)
  );

  dot_product_engine #(.Para_Deg(PD), .Data_Width_In(DWI), .Data_Width_Out(DWO),
                       .Len_Width(LW), .Saturate(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .start(start), .vec_beats(vec_beats),
    .acc_old(acc_old), .bias_in(bias_in), .last_mask(last_mask),
    .busy(busy_w), .beat_count(bc_w), .io(if_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every result handshake pops one expectation per engine.
  always @(negedge clk) begin
    if (reset_n && if_s.out_valid && out_ready) begin
      if (q_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL sat_unexpected: got result %0d, expected none", if_s.out_data);
      end else begin
        exp_t e;
        e = q_s.pop_front();
        chk("sat_data", 64'(if_s.out_data), 64'(e.data));
        chk("sat_flag", 64'(if_s.out_sat), 64'(e.sat));
      end
    end
    if (reset_n && if_w.out_valid && out_ready) begin
      if (q_w.size() == 0) begin
        checks++; errors++;
        $display("FAIL wrap_unexpected: got result %0d, expected none", if_w.out_data);
      end else begin
        exp_t e;
        e = q_w.pop_front();
        chk("wrap_data", 64'(if_w.out_data), 64'(e.data));
        chk("wrap_flag", 64'(if_w.out_sat), 64'(e.sat));
      end
    end
  end

  task automatic issue_start(input int nb, input bit ao, input logic [DWO-1:0] bias,
                             input logic [PD-1:0] mask);
    start = 1'b1; vec_beats = LW'(nb); acc_old = ao; bias_in = bias; last_mask = mask;
    @(posedge clk); #1;
    // Scramble command inputs: the engine must have latched them.
    start = 1'b0; vec_beats = LW'($urandom); acc_old = 1'($urandom);
    bias_in = DWO'($urandom); last_mask = PD'($urandom);
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = (if_s.in_ready === 1'b1);
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no in_ready in 20 cycles, expected acceptance");
    end
  endtask

  task automatic run_vec(input int nb, input bit ao, input logic [DWO-1:0] bias,
                         input logic [PD-1:0] mask, input int gap, input int stall,
                         input bit rdy_early, input int mode,
                         input logic [31:0] fa, input logic [31:0] fb);
    logic [31:0] av[$];
    logic [31:0] bv[$];
    logic [31:0] ta, tb;
    longint total;
    exp_t es, ew;
    int n;
    for (int i = 0; i < nb; i++) begin
      if (mode == 0) begin
        ta = fa; tb = fb;
      end else begin
        for (int l = 0; l < PD; l++) begin
          ta[l*8 +: 8] = 8'($urandom_range(0, (mode == 2) ? 255 : 15));
          tb[l*8 +: 8] = 8'($urandom_range(0, (mode == 2) ? 255 : 15));
        end
      end
      av.push_back(ta); bv.push_back(tb);
    end
    // Reference: exact sum of enabled lane products over the whole vector.
    total = ao ? longint'(bias) : 0;
    for (int i = 0; i < nb; i++) begin
      ta = av[i]; tb = bv[i];
      for (int l = 0; l < PD; l++)
        if (i < nb - 1 || mask[l])
          total += longint'(ta[l*8 +: 8]) * longint'(tb[l*8 +: 8]);
    end
    es.sat  = (total > 65535);
    es.data = es.sat ? 16'hFFFF : 16'(total);
    ew.sat  = es.sat;
    ew.data = 16'(total);
    q_s.push_back(es);
    q_w.push_back(ew);

    out_ready = rdy_early;
    issue_start(nb, ao, bias, mask);
    for (int i = 0; i < nb; i++) begin
      n = (gap < 0) ? 1 : ((gap > 0) ? $urandom_range(0, 2) : 0);
      if (i > 0) begin
        repeat (n) begin
          in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
          @(posedge clk); #1;
        end
      end
      send_beat(av[i], bv[i]);
    end
    // Junk beats offered during DRAIN must be ignored.
    in_valid = (nb > 0); in_a = $urandom; in_b = $urandom;
    n = 0;
    while (if_s.out_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(n), (nb == 0) ? 64'd0 : 64'd2);
    chk("wrap_valid", 64'(if_w.out_valid), 64'd1);
    chk("beat_count", 64'(bc_s), 64'(nb));
    if (!rdy_early) begin
      for (int s = 0; s < stall; s++) begin
        chk("hold_valid", 64'(if_s.out_valid), 64'd1);
        chk("hold_sat_data", 64'(if_s.out_data), 64'(es.data));
        chk("hold_wrap_data", 64'(if_w.out_data), 64'(ew.data));
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy_s), 64'd0);
    chk("idle_valid", 64'(if_s.out_valid), 64'd0);
    chk("idle_beat_count", 64'(bc_s), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    reset_n = 1'b1; start = 1'b0; acc_old = 1'b0; vec_beats = '0; bias_in = '0;
    last_mask = '0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(if_s.in_ready), 64'd0);
    chk("rst_out_valid", 64'(if_s.out_valid), 64'd0);
    chk("rst_out_data", 64'(if_s.out_data), 64'd0);
    chk("rst_out_sat", 64'(if_s.out_sat), 64'd0);
    chk("rst_busy", 64'(busy_s), 64'd0);
    chk("rst_beat_count", 64'(bc_s), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic, with out_ready high throughout DRAIN
    run_vec(4, 0, 16'd0, 4'hF, 0, 0, 1, 0, 32'h04030201, 32'h01010101);
    // Bias
    run_vec(1, 1, 16'd100, 4'hF, 0, 0, 0, 0, 32'h0000000A, 32'h00000005);
    // Overflow: both saturate and wrap engines
    run_vec(4, 0, 16'd0, 4'hF, 0, 2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    // Backpressure: alternating in_valid, 5 stalled cycles in DONE
    run_vec(3, 0, 16'd0, 4'hF, -1, 5, 0, 0, 32'h01010101, 32'h01010101);
    // Last-beat mask and zero-length with bias
    run_vec(2, 0, 16'd0, 4'b0011, 0, 1, 0, 0, 32'h02020202, 32'h02020202);
    run_vec(0, 1, 16'd7, 4'hF, 0, 1, 0, 0, 32'h0, 32'h0);

    // Reset mid-run after 2 of 4 beats: no output, everything cleared
    issue_start(4, 1, 16'd500, 4'hF);
    send_beat($urandom, $urandom);
    send_beat($urandom, $urandom);
    in_valid = 1'b0;
    chk("pre_rst_beat_count", 64'(bc_s), 64'd2);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_in_ready", 64'(if_s.in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(if_s.out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(if_s.out_data), 64'd0);
    chk("mid_rst_out_sat", 64'(if_s.out_sat), 64'd0);
    chk("mid_rst_busy", 64'(busy_s), 64'd0);
    chk("mid_rst_beat_count", 64'(bc_s), 64'd0);
    chk("mid_rst_wrap_busy", 64'(busy_w), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_vec(4, 0, 16'd0, 4'hF, 0, 0, 1, 0, 32'h04030201, 32'h01010101);

    for (int r = 0; r < 25; r++) begin
      nb = $urandom_range(0, 6);
      run_vec(nb, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65000, 65535))
                                          : 16'($urandom_range(0, 1000)),
              4'($urandom), $urandom_range(0, 1), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), $urandom_range(1, 2), 32'h0, 32'h0);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(q_s.size() + q_w.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
